memory_register_file: RTL and testbench



---
 rtl/memory_register_file.sv | 136 +++++++++++++
 tb/tb_memory_register_file.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_register_file.sv
// Valid-tagged storage array behind a single-command port: read, byte-masked
// write, delete and a DEPTH-cycle clear-all sweep, with occupancy/free-slot status.

module memory_register_file_entry #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               de,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] byte_en,
  output logic               valid,
  output logic [WIDTH-1:0]   data
);
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (de) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (we) begin
      valid <= 1'b1;
      // Disabled bytes of a previously empty entry start from zero, not stale data.
      for (int b = 0; b < WIDTH/8; b++)
        data[b*8 +: 8] <= byte_en[b] ? wr_data[b*8 +: 8] : (valid ? data[b*8 +: 8] : 8'h00);
    end
  end
endmodule

module memory_register_file #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [1:0]         op_code,
  input  logic [IDX_W-1:0]   op_idx,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] byte_en,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_hit,
  output logic [DEPTH-1:0]   used_mask,
  output logic [IDX_W:0]     count,
  output logic               full,
  output logic               empty,
  output logic [IDX_W-1:0]   free_idx
);
  typedef enum logic {IDLE, CLEARING} state_t;

  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH-1);

  state_t                       state;
  logic [IDX_W-1:0]             ptr;
  logic [DEPTH-1:0][WIDTH-1:0]  ent_data;
  logic                         acc, idx_ok, rd_acc, wr_acc, del_acc, clr_acc, sel_hit;

  assign op_ready = (state == IDLE);
  assign acc      = op_valid && op_ready;
  assign idx_ok   = {1'b0, op_idx} < DEPTH_C;
  assign rd_acc   = acc && (op_code == 2'b00);
  assign wr_acc   = acc && (op_code == 2'b01) && idx_ok;
  assign del_acc  = acc && (op_code == 2'b10) && idx_ok;
  assign clr_acc  = acc && (op_code == 2'b11);
  assign sel_hit  = idx_ok && used_mask[op_idx];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [IDX_W-1:0] I = IDX_W'(i);
    memory_register_file_entry #(.WIDTH(WIDTH)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_acc && (op_idx == I)),
      .de      ((del_acc && (op_idx == I)) || ((state == CLEARING) && (ptr == I))),
      .wr_data (wr_data),
      .byte_en (byte_en),
      .valid   (used_mask[i]),
      .data    (ent_data[i])
    );
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: if (clr_acc) begin
          state <= CLEARING;
          ptr   <= '0;
        end
        CLEARING: if (ptr == LAST) begin
          state <= IDLE;
          ptr   <= '0;
        end else begin
          ptr <= ptr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rd_data only moves on an accepted READ so it holds between pulses.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_hit  <= sel_hit;
        rd_data <= sel_hit ? ent_data[op_idx] : '0;
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + (IDX_W+1)'(used_mask[i]);
  end

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!used_mask[i]) free_idx = IDX_W'(i);
  end
endmodule

// File: tb/tb_memory_register_file.sv
// Directed bench: a 16-entry array for the main features and a 12-entry
// array for out-of-range indices.

module tb_memory_register_file;
  logic        clk = 1'b0, rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [3:0]  op_idx = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  byte_en = '0;
  logic        op_ready, rd_valid, rd_hit, full, empty;
  logic [63:0] rd_data;
  logic [15:0] used_mask;
  logic [4:0]  count;
  logic [3:0]  free_idx;

  logic        op_valid_b = 1'b0;
  logic [1:0]  op_code_b = 2'b00;
  logic [3:0]  op_idx_b = '0;
  logic [63:0] wr_data_b = '0;
  logic [7:0]  byte_en_b = '0;
  logic        op_ready_b, rd_valid_b, rd_hit_b, full_b, empty_b;
  logic [63:0] rd_data_b;
  logic [11:0] used_mask_b;
  logic [4:0]  count_b;
  logic [3:0]  free_idx_b;

  int total = 0;
  int bad = 0;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, DEL = 2'b10, CLR = 2'b11;

  always #5 clk = ~clk;

  memory_register_file #(.WIDTH(64), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_idx(op_idx), .wr_data(wr_data), .byte_en(byte_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_hit(rd_hit), .used_mask(used_mask), .count(count),
    .full(full), .empty(empty), .free_idx(free_idx)
  );

  memory_register_file #(.WIDTH(64), .DEPTH(12)) dut_b (
    .clk(clk), .rst(rst), .op_valid(op_valid_b), .op_ready(op_ready_b), .op_code(op_code_b),
    .op_idx(op_idx_b), .wr_data(wr_data_b), .byte_en(byte_en_b), .rd_valid(rd_valid_b),
    .rd_data(rd_data_b), .rd_hit(rd_hit_b), .used_mask(used_mask_b), .count(count_b),
    .full(full_b), .empty(empty_b), .free_idx(free_idx_b)
  );

  // Present one command at the rising edge, let the falling edge take it,
  // return 1 time unit after that edge with outputs settled.
  task automatic do_op(input logic [1:0] c, input logic [3:0] i, input logic [63:0] d, input logic [7:0] be);
    @(posedge clk);
    op_valid = 1'b1; op_code = c; op_idx = i; wr_data = d; byte_en = be;
    @(negedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic do_op_b(input logic [1:0] c, input logic [3:0] i, input logic [63:0] d, input logic [7:0] be);
    @(posedge clk);
    op_valid_b = 1'b1; op_code_b = c; op_idx_b = i; wr_data_b = d; byte_en_b = be;
    @(negedge clk); #1;
    op_valid_b = 1'b0;
  endtask

  task automatic pulse_rst();
    @(posedge clk); rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (op_ready !== 1'b1 || rd_valid !== 1'b0 || rd_hit !== 1'b0) begin bad++; $display("FAIL reset_ctl got ready=%b rv=%b hit=%b exp 1 0 0", op_ready, rd_valid, rd_hit); end
    total++; if (rd_data !== 64'h0 || used_mask !== 16'h0) begin bad++; $display("FAIL reset_data got data=%h mask=%h exp 0 0", rd_data, used_mask); end
    total++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || free_idx !== 4'd0) begin bad++; $display("FAIL reset_status got cnt=%0d e=%b f=%b free=%0d exp 0 1 0 0", count, empty, full, free_idx); end
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk); #1;
    total++; if (op_ready !== 1'b1 || count !== 5'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL post_reset got ready=%b cnt=%0d rv=%b exp 1 0 0", op_ready, count, rd_valid); end
  endtask

  task automatic test_write_read();
    do_op(WR, 4'd3, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    total++; if (count !== 5'd1 || free_idx !== 4'd0 || used_mask !== 16'h0008) begin bad++; $display("FAIL wr3_status got cnt=%0d free=%0d mask=%h exp 1 0 0008", count, free_idx, used_mask); end
    do_op(RD, 4'd3, 64'h0, 8'h00);
    total++; if (rd_valid !== 1'b1 || rd_hit !== 1'b1 || rd_data !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL rd3 got rv=%b hit=%b data=%h exp 1 1 deadbeefcafef00d", rd_valid, rd_hit, rd_data); end
    @(negedge clk); #1;
    total++; if (rd_valid !== 1'b0 || rd_data !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL rd_pulse got rv=%b data=%h exp 0 deadbeefcafef00d", rd_valid, rd_data); end
  endtask

  task automatic test_partial();
    do_op(WR, 4'd5, 64'h11223344_55667788, 8'hFF);
    do_op(WR, 4'd5, 64'hAAAAAAAA_AAAAAAAA, 8'h0F);
    do_op(RD, 4'd5, 64'h0, 8'h00);
    total++; if (rd_hit !== 1'b1 || rd_data !== 64'h11223344_AAAAAAAA) begin bad++; $display("FAIL partial_valid got hit=%b data=%h exp 1 11223344aaaaaaaa", rd_hit, rd_data); end
    do_op(WR, 4'd6, 64'hFFFFFFFF_FFFFFF77, 8'h01);
    do_op(RD, 4'd6, 64'h0, 8'h00);
    total++; if (rd_hit !== 1'b1 || rd_data !== 64'h00000000_00000077) begin bad++; $display("FAIL partial_invalid got hit=%b data=%h exp 1 77", rd_hit, rd_data); end
    do_op(RD, 4'd7, 64'h0, 8'h00);
    total++; if (rd_valid !== 1'b1 || rd_hit !== 1'b0 || rd_data !== 64'h0) begin bad++; $display("FAIL rd_miss got rv=%b hit=%b data=%h exp 1 0 0", rd_valid, rd_hit, rd_data); end
    do_op(WR, 4'd8, 64'h12345678_9ABCDEF0, 8'h00);
    do_op(RD, 4'd8, 64'h0, 8'h00);
    total++; if (rd_hit !== 1'b1 || rd_data !== 64'h0 || count !== 5'd4) begin bad++; $display("FAIL be_zero got hit=%b data=%h cnt=%0d exp 1 0 4", rd_hit, rd_data, count); end
  endtask

  task automatic test_fill_delete();
    for (int i = 0; i < 16; i++) do_op(WR, 4'(i), 64'h01010101_01010101 * 64'(i), 8'hFF);
    total++; if (full !== 1'b1 || count !== 5'd16 || empty !== 1'b0 || free_idx !== 4'd0 || used_mask !== 16'hFFFF) begin bad++; $display("FAIL full got f=%b cnt=%0d e=%b free=%0d mask=%h exp 1 16 0 0 ffff", full, count, empty, free_idx, used_mask); end
    do_op(DEL, 4'd9, 64'h0, 8'h00);
    total++; if (full !== 1'b0 || free_idx !== 4'd9 || count !== 5'd15) begin bad++; $display("FAIL del9 got f=%b free=%0d cnt=%0d exp 0 9 15", full, free_idx, count); end
    do_op(DEL, 4'd9, 64'h0, 8'h00);
    total++; if (count !== 5'd15 || used_mask !== 16'hFDFF) begin bad++; $display("FAIL del9_again got cnt=%0d mask=%h exp 15 fdff", count, used_mask); end
    do_op(RD, 4'd9, 64'h0, 8'h00);
    total++; if (rd_hit !== 1'b0 || rd_data !== 64'h0) begin bad++; $display("FAIL rd_deleted got hit=%b data=%h exp 0 0", rd_hit, rd_data); end
    do_op(RD, 4'd10, 64'h0, 8'h00);
    total++; if (rd_hit !== 1'b1 || rd_data !== 64'h0A0A0A0A_0A0A0A0A) begin bad++; $display("FAIL rd10 got hit=%b data=%h exp 1 0a0a0a0a0a0a0a0a", rd_hit, rd_data); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    op_valid = 1'b1; op_code = RD; op_idx = 4'd3;
    @(negedge clk); #1;
    total++; if (rd_valid !== 1'b1 || rd_data !== 64'h03030303_03030303) begin bad++; $display("FAIL b2b_first got rv=%b data=%h exp 1 0303030303030303", rd_valid, rd_data); end
    op_idx = 4'd4;
    @(negedge clk); #1;
    op_valid = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 64'h04040404_04040404) begin bad++; $display("FAIL b2b_second got rv=%b data=%h exp 1 0404040404040404", rd_valid, rd_data); end
    @(negedge clk); #1;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got rv=%b exp 0", rd_valid); end
  endtask

  task automatic test_clear_all();
    int low;
    pulse_rst();
    do_op(WR, 4'd0, 64'h1, 8'hFF);
    do_op(WR, 4'd1, 64'h2, 8'hFF);
    do_op(WR, 4'd2, 64'h3, 8'hFF);
    do_op(WR, 4'd7, 64'h4, 8'hFF);
    total++; if (count !== 5'd4) begin bad++; $display("FAIL pre_clear got cnt=%0d exp 4", count); end
    @(posedge clk);
    op_valid = 1'b1; op_code = CLR; op_idx = 4'd0;
    @(negedge clk); #1;
    total++; if (op_ready !== 1'b0 || count !== 5'd4) begin bad++; $display("FAIL clr_accept got ready=%b cnt=%0d exp 0 4", op_ready, count); end
    op_code = WR; op_idx = 4'd4; wr_data = 64'h44444444_44444444; byte_en = 8'hFF;
    low = 0;
    @(posedge clk);
    while (!op_ready && low < 40) begin
      low++;
      @(posedge clk);
    end
    total++; if (low !== 16) begin bad++; $display("FAIL clr_busy got %0d cycles exp 16", low); end
    total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL clr_empty got cnt=%0d e=%b exp 0 1", count, empty); end
    @(negedge clk); #1;
    op_valid = 1'b0;
    total++; if (used_mask !== 16'h0010 || count !== 5'd1) begin bad++; $display("FAIL held_write got mask=%h cnt=%0d exp 0010 1", used_mask, count); end
    do_op(RD, 4'd4, 64'h0, 8'h00);
    total++; if (rd_hit !== 1'b1 || rd_data !== 64'h44444444_44444444) begin bad++; $display("FAIL held_data got hit=%b data=%h exp 1 4444444444444444", rd_hit, rd_data); end
  endtask

  task automatic test_reset_mid_sweep();
    pulse_rst();
    do_op(WR, 4'd2, 64'h22, 8'hFF);
    do_op(WR, 4'd10, 64'hAA, 8'hFF);
    do_op(WR, 4'd11, 64'hBB, 8'hFF);
    do_op(CLR, 4'd0, 64'h0, 8'h00);
    repeat (4) @(negedge clk);
    #1;
    total++; if (count !== 5'd2 || used_mask !== 16'h0C00 || op_ready !== 1'b0) begin bad++; $display("FAIL sweep_progress got cnt=%0d mask=%h ready=%b exp 2 0c00 0", count, used_mask, op_ready); end
    @(posedge clk); rst = 1'b1;
    #1;
    total++; if (op_ready !== 1'b1 || used_mask !== 16'h0 || count !== 5'd0) begin bad++; $display("FAIL async_rst got ready=%b mask=%h cnt=%0d exp 1 0 0", op_ready, used_mask, count); end
    repeat (2) @(posedge clk);
    rst = 1'b0;
    do_op(RD, 4'd10, 64'h0, 8'h00);
    total++; if (rd_valid !== 1'b1 || rd_hit !== 1'b0 || rd_data !== 64'h0) begin bad++; $display("FAIL rd_after_rst got rv=%b hit=%b data=%h exp 1 0 0", rd_valid, rd_hit, rd_data); end
  endtask

  task automatic test_npot();
    pulse_rst();
    do_op_b(WR, 4'd3, 64'h33, 8'hFF);
    do_op_b(WR, 4'd13, 64'hDD, 8'hFF);
    total++; if (count_b !== 5'd1 || used_mask_b !== 12'h008) begin bad++; $display("FAIL npot_wr13 got cnt=%0d mask=%h exp 1 008", count_b, used_mask_b); end
    do_op_b(RD, 4'd13, 64'h0, 8'h00);
    total++; if (rd_valid_b !== 1'b1 || rd_hit_b !== 1'b0 || rd_data_b !== 64'h0) begin bad++; $display("FAIL npot_rd13 got rv=%b hit=%b data=%h exp 1 0 0", rd_valid_b, rd_hit_b, rd_data_b); end
    do_op_b(DEL, 4'd13, 64'h0, 8'h00);
    total++; if (count_b !== 5'd1) begin bad++; $display("FAIL npot_del13 got cnt=%0d exp 1", count_b); end
    for (int i = 0; i < 12; i++) do_op_b(WR, 4'(i), 64'(i), 8'hFF);
    total++; if (full_b !== 1'b1 || count_b !== 5'd12 || free_idx_b !== 4'd0 || empty_b !== 1'b0) begin bad++; $display("FAIL npot_full got f=%b cnt=%0d free=%0d e=%b exp 1 12 0 0", full_b, count_b, free_idx_b, empty_b); end
    total++; if (op_ready_b !== 1'b1) begin bad++; $display("FAIL npot_ready got %b exp 1", op_ready_b); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_fill_delete();
    test_back_to_back();
    test_clear_all();
    test_reset_mid_sweep();
    test_npot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
